id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode/issue stage sitting between the IF/ID register and the EX stage. Drives the register file read
//  addresses from the IF/ID instruction and decodes RV64I control. Generates immediates and detects
//  load-use hazards. Registers everything into the ID/EX pipeline register with stall, bubble and flush control.
// PARAMETERS
//  XLEN      64   datapath width (register data, PC, immediate)
//  ALUOP_W   2    width of alu_op field (00 add, 01 sub/branch, 10 funct-decoded)
// PORTS
//  clk            in   1     pipeline clock; ID/EX updates on posedge
//  reset          in   1     synchronous, active-high
//  if_id_valid    in   1     IF/ID holds a real instruction
//  if_id_instr    in   32    instruction word
//  if_id_pc       in   XLEN  instruction PC
//  rf_read_reg1   out  5     = instr[19:15], combinational
//  rf_read_reg2   out  5     = instr[24:20], combinational
//  rf_read_data1  in   XLEN  register file port 1 data
//  rf_read_data2  in   XLEN  register file port 2 data
//  wb_reg_write   in   1     writeback write enable (bypass only)
//  wb_rd          in   5     writeback destination (bypass only)
//  wb_data        in   XLEN  writeback data (bypass only)
//  ex_flush       in   1     branch taken in EX: squash IF/ID contents
//  ex_hold        in   1     downstream cannot accept: freeze ID/EX
//  if_id_stall    out  1     hold PC and IF/ID this cycle (combinational)
//  id_ex_valid    out  1     ID/EX entry is real; 0 = bubble
//  id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm   out XLEN
//  id_ex_rs1, id_ex_rs2, id_ex_rd                         out 5
//  id_ex_funct3 out 3; id_ex_funct7b5 out 1; id_ex_alu_op out ALUOP_W
//  id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src, id_ex_branch  out 1
// BEHAVIOUR
//  - Reset (sync, priority over all): every id_ex_* output goes to 0, including valid and all control bits.
//  - Decode: opcodes R 0110011, I-ALU 0010011, LD 0000011, SD 0100011, BEQ 1100011.
//    Any other opcode decodes as a NOP with all controls 0 and valid still 1.
//  - Immediate: I = sext(instr[31:20]); S = sext({[31:25],[11:7]}); B = sext({[31],[7],[30:25],[11:8],1'b0}).
//    Immediate is 0 for R-type.
//  - Rs usage: rs1 is used by all five classes; rs2 is used by R, SD and BEQ only.
//  - Hazard = if_id_valid & id_ex_valid & id_ex_mem_read & id_ex_rd!=0 & id_ex_rd matches a used rs.
//  - Per posedge, first matching row wins:
//      1 reset                    -> clear ID/EX
//      2 ex_hold                  -> ID/EX retains its value; if_id_stall=1
//      3 ex_flush                 -> load bubble (valid=0, controls 0); if_id_stall=0, flush beats hazard
//      4 hazard                   -> load bubble; if_id_stall=1; exactly one bubble per load-use pair
//      5 !if_id_valid             -> load bubble
//      6 otherwise                -> load decoded instruction, valid=1
//  - Latency: 1 cycle from IF/ID to ID/EX. The datapath fields of a bubble are don't-care; the bench checks only valid and controls.
//  - Reading x0 returns 0. Data is taken as supplied; the register file writes on the falling clock edge,
//    so a same-cycle WB write is already visible on rf_read_data*.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//    - if wb_reg_write & wb_rd!=0 & wb_rd==rsN, rsN data = wb_data instead of rf_read_dataN.
//    - Allows a posedge-writing register file.
//  Not defined:
//    - rf_read_data* passes straight through; wb_* ports exist but are ignored.
// STRUCTURE
//  Shared package pipi_pkg: opcode localparams, ALU_OP_ADD/SUB/FUNCT, XLEN.
//  Sub-module imm_gen (combinational, instr -> XLEN immediate), one instance.
//  Decode, hazard logic and the ID/EX register stay in this module.
// TESTING
//  1 reset=1 for 2 cycles with a valid ADD in IF/ID -> all id_ex_* 0; first cycle after release loads the ADD, valid=1.
//  2 add x3,x1,x2 (rf1=5, rf2=7) -> next cycle: rs1_data=5, rs2_data=7, reg_write=1, alu_src=0, alu_op=10, rd=3.
//  3 ld x5,8(x1) then add x6,x5,x2 -> stall=1 for one cycle with one bubble, then add issues.
//    Same sequence with rd=x0 -> no stall.
//  4 sd x5,-4(x2) -> imm=0xFFFF_FFFF_FFFF_FFFC, mem_write=1, reg_write=0.
//    beq imm=-8 -> imm=...FFF8, branch=1, alu_op=01.
//  5 hazard and ex_flush asserted together -> bubble, stall=0.
//    ex_hold=1 for 3 cycles -> ID/EX unchanged, stall=1 throughout.
//  6 WB_BYPASS_EN: wb_rd=1, wb_data=0xAA, rf1=0x11, rs1=1 -> rs1_data=0xAA.
//    Same stimulus without the macro -> 0x11.

Source files
------------

// File: rtl/pipi_pkg.sv
// Shared pipeline definitions: datapath width, RV64I opcodes, ALU op codes,
// instruction classes and the packed control word carried into ID/EX.
package pipi_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned ALUOP_W = 2;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_R,
    CLS_I,
    CLS_LD,
    CLS_SD,
    CLS_BR
  } instr_class_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic instr_class_e classify(input logic [6:0] opcode);
    case (opcode)
      OP_R:    return CLS_R;
      OP_I:    return CLS_I;
      OP_LD:   return CLS_LD;
      OP_SD:   return CLS_SD;
      OP_BEQ:  return CLS_BR;
      default: return CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// imm_gen: combinational immediate generator, instruction word -> sign-extended
// XLEN immediate (I, S and B formats; zero for R-type and unknown opcodes).
module imm_gen
  import pipi_pkg::*;
#(
  parameter int unsigned XLEN = pipi_pkg::XLEN
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm
);

  instr_class_e w_cls;

  assign w_cls = classify(i_instr[6:0]);

  always_comb begin
    o_imm = '0;
    case (w_cls)
      CLS_I, CLS_LD: o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
      CLS_SD:        o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      CLS_BR:        o_imm = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
      default:       o_imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV64I decode, load-use hazard detection and the ID/EX register.
// Define WB_BYPASS_EN to forward the writeback port onto the operand data.
module id_ex_stage
  import pipi_pkg::*;
#(
  parameter int unsigned XLEN    = pipi_pkg::XLEN,
  parameter int unsigned ALUOP_W = pipi_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_id_valid,
  input  logic [31:0]        if_id_instr,
  input  logic [XLEN-1:0]    if_id_pc,
  output logic [4:0]         rf_read_reg1,
  output logic [4:0]         rf_read_reg2,
  input  logic [XLEN-1:0]    rf_read_data1,
  input  logic [XLEN-1:0]    rf_read_data2,
  input  logic               wb_reg_write,
  input  logic [4:0]         wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               ex_flush,
  input  logic               ex_hold,
  output logic               if_id_stall,
  output logic               id_ex_valid,
  output logic [XLEN-1:0]    id_ex_pc,
  output logic [XLEN-1:0]    id_ex_rs1_data,
  output logic [XLEN-1:0]    id_ex_rs2_data,
  output logic [XLEN-1:0]    id_ex_imm,
  output logic [4:0]         id_ex_rs1,
  output logic [4:0]         id_ex_rs2,
  output logic [4:0]         id_ex_rd,
  output logic [2:0]         id_ex_funct3,
  output logic               id_ex_funct7b5,
  output logic [ALUOP_W-1:0] id_ex_alu_op,
  output logic               id_ex_reg_write,
  output logic               id_ex_mem_read,
  output logic               id_ex_mem_write,
  output logic               id_ex_mem_to_reg,
  output logic               id_ex_alu_src,
  output logic               id_ex_branch
);

  instr_class_e    w_cls;
  ctrl_t           w_ctrl;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic            w_uses_rs1, w_uses_rs2, w_hazard, w_bubble;
  logic [XLEN-1:0] w_imm, w_rs1_data, w_rs2_data;

  logic            r_valid;
  ctrl_t           r_ctrl;
  logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]      r_rs1, r_rs2, r_rd;
  logic [2:0]      r_funct3;
  logic            r_funct7b5;

  assign w_cls        = classify(if_id_instr[6:0]);
  assign w_rs1        = if_id_instr[19:15];
  assign w_rs2        = if_id_instr[24:20];
  assign w_rd         = if_id_instr[11:7];
  assign rf_read_reg1 = w_rs1;
  assign rf_read_reg2 = w_rs2;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (if_id_instr),
    .o_imm   (w_imm)
  );

  always_comb begin
    w_ctrl = '0;
    case (w_cls)
      CLS_R:  begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_OP_FUNCT; end
      CLS_I:  begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_src = 1'b1; w_ctrl.alu_op = ALU_OP_FUNCT; end
      CLS_LD: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.alu_op     = ALU_OP_ADD;
      end
      CLS_SD: begin w_ctrl.mem_write = 1'b1; w_ctrl.alu_src = 1'b1; w_ctrl.alu_op = ALU_OP_ADD; end
      CLS_BR: begin w_ctrl.branch = 1'b1; w_ctrl.alu_op = ALU_OP_SUB; end
      default: w_ctrl = '0;
    endcase
  end

  // Unknown opcodes read no registers, so they never trigger a load-use stall.
  assign w_uses_rs1 = (w_cls != CLS_NOP);
  assign w_uses_rs2 = (w_cls == CLS_R) || (w_cls == CLS_SD) || (w_cls == CLS_BR);
  assign w_hazard   = if_id_valid && r_valid && r_ctrl.mem_read && (r_rd != 5'd0) &&
                      ((w_uses_rs1 && (r_rd == w_rs1)) || (w_uses_rs2 && (r_rd == w_rs2)));

  assign if_id_stall = ex_hold || (!ex_flush && w_hazard);
  assign w_bubble    = ex_flush || w_hazard || !if_id_valid;

`ifdef WB_BYPASS_EN
  assign w_rs1_data = (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == w_rs1)) ? wb_data : rf_read_data1;
  assign w_rs2_data = (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == w_rs2)) ? wb_data : rf_read_data2;
`else
  assign w_rs1_data = rf_read_data1;
  assign w_rs2_data = rf_read_data2;
`endif

  // Datapath fields load on every non-held cycle; only valid/controls are squashed for a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
    end else if (!ex_hold) begin
      r_valid    <= !w_bubble;
      r_ctrl     <= w_bubble ? '0 : w_ctrl;
      r_pc       <= if_id_pc;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_imm      <= w_imm;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
      r_funct3   <= if_id_instr[14:12];
      r_funct7b5 <= if_id_instr[30];
    end
  end

  assign id_ex_valid      = r_valid;
  assign id_ex_pc         = r_pc;
  assign id_ex_rs1_data   = r_rs1_data;
  assign id_ex_rs2_data   = r_rs2_data;
  assign id_ex_imm        = r_imm;
  assign id_ex_rs1        = r_rs1;
  assign id_ex_rs2        = r_rs2;
  assign id_ex_rd         = r_rd;
  assign id_ex_funct3     = r_funct3;
  assign id_ex_funct7b5   = r_funct7b5;
  assign id_ex_alu_op     = ALUOP_W'(r_ctrl.alu_op);
  assign id_ex_reg_write  = r_ctrl.reg_write;
  assign id_ex_mem_read   = r_ctrl.mem_read;
  assign id_ex_mem_write  = r_ctrl.mem_write;
  assign id_ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign id_ex_alu_src    = r_ctrl.alu_src;
  assign id_ex_branch     = r_ctrl.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow WB_BYPASS_EN
// when the bench is built with that macro.
module tb_id_ex_stage;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            reset, if_id_valid, wb_reg_write, ex_flush, ex_hold;
  logic [31:0]     if_id_instr;
  logic [XLEN-1:0] if_id_pc, rf_read_data1, rf_read_data2, wb_data;
  logic [4:0]      wb_rd, rf_read_reg1, rf_read_reg2;
  logic            if_id_stall, id_ex_valid, id_ex_funct7b5;
  logic [XLEN-1:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]      id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [2:0]      id_ex_funct3;
  logic [1:0]      id_ex_alu_op;
  logic            id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
  logic            id_ex_mem_to_reg, id_ex_alu_src, id_ex_branch;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .ALUOP_W(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_id_valid      (if_id_valid),
    .if_id_instr      (if_id_instr),
    .if_id_pc         (if_id_pc),
    .rf_read_reg1     (rf_read_reg1),
    .rf_read_reg2     (rf_read_reg2),
    .rf_read_data1    (rf_read_data1),
    .rf_read_data2    (rf_read_data2),
    .wb_reg_write     (wb_reg_write),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .ex_flush         (ex_flush),
    .ex_hold          (ex_hold),
    .if_id_stall      (if_id_stall),
    .id_ex_valid      (id_ex_valid),
    .id_ex_pc         (id_ex_pc),
    .id_ex_rs1_data   (id_ex_rs1_data),
    .id_ex_rs2_data   (id_ex_rs2_data),
    .id_ex_imm        (id_ex_imm),
    .id_ex_rs1        (id_ex_rs1),
    .id_ex_rs2        (id_ex_rs2),
    .id_ex_rd         (id_ex_rd),
    .id_ex_funct3     (id_ex_funct3),
    .id_ex_funct7b5   (id_ex_funct7b5),
    .id_ex_alu_op     (id_ex_alu_op),
    .id_ex_reg_write  (id_ex_reg_write),
    .id_ex_mem_read   (id_ex_mem_read),
    .id_ex_mem_write  (id_ex_mem_write),
    .id_ex_mem_to_reg (id_ex_mem_to_reg),
    .id_ex_alu_src    (id_ex_alu_src),
    .id_ex_branch     (id_ex_branch)
  );

  // Control word: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op[1:0]}
  logic [7:0] w_ctrl;
  assign w_ctrl = {id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
                   id_ex_alu_src, id_ex_branch, id_ex_alu_op};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; if_id_valid = 1'b1; if_id_instr = r_type(5'd2, 5'd1, 5'd3);
    if_id_pc = 64'h100; rf_read_data1 = 64'd5; rf_read_data2 = 64'd7;
    wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = '0; ex_flush = 1'b0; ex_hold = 1'b0;

    // Reset held two cycles with a valid ADD presented
    tick();
    check("rst1_valid", id_ex_valid, 1'b0);
    check("rst1_ctrl",  w_ctrl, 8'h00);
    tick();
    check("rst2_valid", id_ex_valid, 1'b0);
    check("rst2_rd",    id_ex_rd, 5'd0);
    check("rst2_pc",    id_ex_pc, 64'h0);
    check("rd_addr1",   rf_read_reg1, 5'd1);
    check("rd_addr2",   rf_read_reg2, 5'd2);
    reset = 1'b0;
    tick();
    check("add_valid", id_ex_valid, 1'b1);
    check("add_rs1d",  id_ex_rs1_data, 64'd5);
    check("add_rs2d",  id_ex_rs2_data, 64'd7);
    check("add_ctrl",  w_ctrl, 8'h82);
    check("add_rd",    id_ex_rd, 5'd3);
    check("add_pc",    id_ex_pc, 64'h100);
    check("add_imm",   id_ex_imm, 64'h0);

    // Load-use: ld x5,8(x1) then add x6,x5,x2
    if_id_instr = i_type(12'd8, 5'd1, 3'b011, 5'd5, 7'b0000011); if_id_pc = 64'h104;
    tick();
    check("ld_ctrl", w_ctrl, 8'hD8);
    check("ld_imm",  id_ex_imm, 64'd8);
    check("ld_rd",   id_ex_rd, 5'd5);
    if_id_instr = r_type(5'd2, 5'd5, 5'd6); if_id_pc = 64'h108;
    #1 check("lu_stall", if_id_stall, 1'b1);
    tick();
    check("lu_bub_valid", id_ex_valid, 1'b0);
    check("lu_bub_ctrl",  w_ctrl, 8'h00);
    check("lu_stall_off", if_id_stall, 1'b0);
    tick();
    check("lu_issue_valid", id_ex_valid, 1'b1);
    check("lu_issue_rd",    id_ex_rd, 5'd6);

    // Load to x0 never stalls
    if_id_instr = i_type(12'd8, 5'd1, 3'b011, 5'd0, 7'b0000011);
    tick();
    if_id_instr = r_type(5'd2, 5'd0, 5'd6);
    #1 check("x0_stall", if_id_stall, 1'b0);
    tick();
    check("x0_valid", id_ex_valid, 1'b1);

    // Immediates and controls
    if_id_instr = s_type(12'hFFC, 5'd5, 5'd2);
    tick();
    check("sd_imm",  id_ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check("sd_ctrl", w_ctrl, 8'h28);
    if_id_instr = b_type(13'h1FF8, 5'd2, 5'd1);
    tick();
    check("beq_imm",  id_ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    check("beq_ctrl", w_ctrl, 8'h05);
    if_id_instr = i_type(12'hFFF, 5'd1, 3'b000, 5'd7, 7'b0010011);
    tick();
    check("addi_imm",  id_ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_ctrl", w_ctrl, 8'h8A);
    if_id_instr = 32'h0000_007F;
    tick();
    check("nop_valid", id_ex_valid, 1'b1);
    check("nop_ctrl",  w_ctrl, 8'h00);
    if_id_valid = 1'b0; if_id_instr = r_type(5'd2, 5'd1, 5'd3);
    tick();
    check("inval_valid", id_ex_valid, 1'b0);
    check("inval_ctrl",  w_ctrl, 8'h00);

    // Flush beats hazard
    if_id_valid = 1'b1; if_id_instr = i_type(12'd8, 5'd1, 3'b011, 5'd5, 7'b0000011);
    tick();
    if_id_instr = r_type(5'd2, 5'd5, 5'd6); ex_flush = 1'b1;
    #1 check("flush_stall", if_id_stall, 1'b0);
    tick();
    check("flush_valid", id_ex_valid, 1'b0);
    check("flush_ctrl",  w_ctrl, 8'h00);
    ex_flush = 1'b0;

    // Hold freezes ID/EX for three cycles
    if_id_instr = r_type(5'd2, 5'd1, 5'd3); if_id_pc = 64'h200; rf_read_data1 = 64'd5;
    tick();
    ex_hold = 1'b1; if_id_instr = i_type(12'd0, 5'd1, 3'b011, 5'd9, 7'b0000011);
    if_id_pc = 64'h300; rf_read_data1 = 64'h99;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_stall", if_id_stall, 1'b1);
      tick();
      check("hold_valid", id_ex_valid, 1'b1);
      check("hold_rd",    id_ex_rd, 5'd3);
      check("hold_pc",    id_ex_pc, 64'h200);
      check("hold_rs1d",  id_ex_rs1_data, 64'd5);
      check("hold_ctrl",  w_ctrl, 8'h82);
    end
    ex_hold = 1'b0;
    tick();
    check("unhold_rd", id_ex_rd, 5'd9);

    // Writeback bypass
    if_id_instr = i_type(12'd0, 5'd1, 3'b000, 5'd4, 7'b0010011);
    rf_read_data1 = 64'h11; wb_reg_write = 1'b1; wb_rd = 5'd1; wb_data = 64'hAA;
    tick();
`ifdef WB_BYPASS_EN
    check("wb_rs1d", id_ex_rs1_data, 64'hAA);
`else
    check("wb_rs1d", id_ex_rs1_data, 64'h11);
`endif
    if_id_instr = i_type(12'd0, 5'd0, 3'b000, 5'd4, 7'b0010011); wb_rd = 5'd0;
    tick();
    check("wb_x0_rs1d", id_ex_rs1_data, 64'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
